imem_port_arbiter: RTL and testbench

//   Shares the single-port instruction memory BRAM between three requesters:
//   the IF stage fetch path, a debug read port and a program loader with write access.

---
 rtl/imem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_imem_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction BRAM between IF fetch, debug reads and the program loader.
// Also holds the instruction presented to IF steady while fetch is stalled.
module imem_port_arbiter #(
    parameter int unsigned INSTR_MEM_LEN = 15,
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [INSTR_MEM_LEN-1:0] if_addr,
    output logic [INSTR_WIDTH-1:0]   if_instr,
    output logic                     if_stall,
    output logic                     if_flush,
    input  logic                     dbg_req_valid,
    input  logic [INSTR_MEM_LEN-1:0] dbg_addr,
    output logic                     dbg_req_ready,
    output logic                     dbg_rsp_valid,
    output logic [INSTR_WIDTH-1:0]   dbg_rsp_data,
    input  logic                     ld_active,
    input  logic                     ld_valid,
    input  logic [INSTR_MEM_LEN-1:0] ld_addr,
    input  logic [INSTR_WIDTH-1:0]   ld_data,
    output logic                     ld_ready,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [INSTR_MEM_LEN-1:0] mem_addr,
    output logic [INSTR_WIDTH-1:0]   mem_wdata,
    input  logic [INSTR_WIDTH-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DBG_RSP = 2'd1,
        LOAD    = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     fetch_grant;
    logic                     fq;
    logic [INSTR_WIDTH-1:0]   hold;

    // State register plus the instruction-hold path for IF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            fq    <= 1'b0;
            hold  <= NOP_INSTR;
        end else begin
            state <= state_next;
            fq    <= fetch_grant;
            if (state == FLUSH) begin
                hold <= NOP_INSTR;
            end else if (fq) begin
                hold <= mem_rdata;
            end
        end
    end

    assign if_instr = fq ? mem_rdata : hold;

    // Next state and port muxing; outputs forced to idle while reset is asserted
    always_comb begin
        state_next    = state;
        fetch_grant   = 1'b0;
        if_stall      = 1'b0;
        if_flush      = 1'b0;
        dbg_req_ready = 1'b0;
        dbg_rsp_valid = 1'b0;
        dbg_rsp_data  = '0;
        ld_ready      = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        case (state)
            FETCH: begin
                if (ld_active) begin
                    if_stall   = 1'b1;
                    mem_addr   = if_addr;
                    state_next = LOAD;
                end else if (dbg_req_valid) begin
                    dbg_req_ready = 1'b1;
                    mem_en        = 1'b1;
                    mem_addr      = dbg_addr;
                    if_stall      = 1'b1;
                    state_next    = DBG_RSP;
                end else begin
                    mem_en      = 1'b1;
                    mem_addr    = if_addr;
                    fetch_grant = 1'b1;
                end
            end
            DBG_RSP: begin
                dbg_rsp_valid = 1'b1;
                dbg_rsp_data  = mem_rdata;
                mem_en        = 1'b1;
                mem_addr      = if_addr;
                fetch_grant   = 1'b1;
                state_next    = FETCH;
            end
            LOAD: begin
                ld_ready  = 1'b1;
                mem_en    = ld_valid;
                mem_we    = ld_valid;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
                if_stall  = 1'b1;
                if (!ld_active) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if_flush   = 1'b1;
                if_stall   = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        if (!rst_n) begin
            fetch_grant   = 1'b0;
            if_stall      = 1'b0;
            if_flush      = 1'b0;
            dbg_req_ready = 1'b0;
            dbg_rsp_valid = 1'b0;
            dbg_rsp_data  = '0;
            ld_ready      = 1'b0;
            mem_en        = 1'b0;
            mem_we        = 1'b0;
            mem_addr      = '0;
            mem_wdata     = '0;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a behavioural read-first BRAM model.
module tb_imem_port_arbiter;

    localparam int unsigned ILEN = 15;
    localparam int unsigned IW   = 32;
    localparam logic [IW-1:0] NOP = 32'h00000013;

    logic            clk;
    logic            rst_n;
    logic [ILEN-1:0] if_addr;
    logic [IW-1:0]   if_instr;
    logic            if_stall;
    logic            if_flush;
    logic            dbg_req_valid;
    logic [ILEN-1:0] dbg_addr;
    logic            dbg_req_ready;
    logic            dbg_rsp_valid;
    logic [IW-1:0]   dbg_rsp_data;
    logic            ld_active;
    logic            ld_valid;
    logic [ILEN-1:0] ld_addr;
    logic [IW-1:0]   ld_data;
    logic            ld_ready;
    logic            mem_en;
    logic            mem_we;
    logic [ILEN-1:0] mem_addr;
    logic [IW-1:0]   mem_wdata;
    logic [IW-1:0]   mem_rdata;

    logic [IW-1:0]   mem [2**ILEN];
    logic            preload;
    int              checks;
    int              errors;

    imem_port_arbiter #(
        .INSTR_MEM_LEN(ILEN),
        .INSTR_WIDTH  (IW),
        .NOP_INSTR    (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_addr      (if_addr),
        .if_instr     (if_instr),
        .if_stall     (if_stall),
        .if_flush     (if_flush),
        .dbg_req_valid(dbg_req_valid),
        .dbg_addr     (dbg_addr),
        .dbg_req_ready(dbg_req_ready),
        .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rsp_data (dbg_rsp_data),
        .ld_active    (ld_active),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: read-first, one-cycle read latency
    always @(posedge clk) begin
        if (preload) begin
            mem[0]     <= 32'h00000100;
            mem[1]     <= 32'h00000101;
            mem[2]     <= 32'h00000102;
            mem[3]     <= 32'h00000103;
            mem[5]     <= 32'h0;
            mem[16]    <= 32'hDEADBEEF;
            mem[32]    <= 32'h0;
            mem_rdata  <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (if_instr !== NOP || if_stall !== 1'b0 || if_flush !== 1'b0 || mem_en !== 1'b0 ||
            mem_we !== 1'b0 || dbg_req_ready !== 1'b0 || dbg_rsp_valid !== 1'b0 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: instr=%h stall=%b flush=%b en=%b we=%b rdy=%b rspv=%b ldr=%b (want %h,0,0,0,0,0,0,0)",
                     if_instr, if_stall, if_flush, mem_en, mem_we, dbg_req_ready, dbg_rsp_valid, ld_ready, NOP);
        end
    endtask

    task automatic test_fetch();
        logic [IW-1:0] exp_instr [4];
        exp_instr[0] = NOP;
        exp_instr[1] = 32'h100;
        exp_instr[2] = 32'h101;
        exp_instr[3] = 32'h102;
        tick();
        preload = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            if_addr = ILEN'(i);
            @(negedge clk);
            checks++;
            if (mem_addr !== ILEN'(i) || mem_en !== 1'b1 || if_stall !== 1'b0) begin
                errors++;
                $display("FAIL fetch_port[%0d]: addr=%h en=%b stall=%b (want %h,1,0)", i, mem_addr, mem_en, if_stall, i);
            end
            if (i != 0) begin
                checks++;
                if (if_instr !== exp_instr[i]) begin
                    errors++;
                    $display("FAIL fetch_instr[%0d]: got %h want %h", i, if_instr, exp_instr[i]);
                end
            end
        end
    endtask

    task automatic test_dbg_alternate();
        tick();
        dbg_req_valid = 1'b1;
        dbg_addr      = ILEN'(16);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            @(negedge clk);
            checks++;
            if (dbg_req_ready !== ((i % 2) == 0) || dbg_rsp_valid !== ((i % 2) == 1) ||
                if_stall !== ((i % 2) == 0) || if_instr !== 32'h103) begin
                errors++;
                $display("FAIL dbg_alt[%0d]: rdy=%b rspv=%b stall=%b instr=%h (want %b,%b,%b,00000103)",
                         i, dbg_req_ready, dbg_rsp_valid, if_stall, if_instr, (i % 2) == 0, (i % 2) == 1, (i % 2) == 0);
            end
            if ((i % 2) == 0) begin
                checks++;
                if (mem_addr !== ILEN'(16)) begin
                    errors++;
                    $display("FAIL dbg_addr[%0d]: got %h want 0010", i, mem_addr);
                end
            end else begin
                checks++;
                if (dbg_rsp_data !== 32'hDEADBEEF || mem_addr !== ILEN'(3)) begin
                    errors++;
                    $display("FAIL dbg_rsp[%0d]: data=%h addr=%h want deadbeef,0003", i, dbg_rsp_data, mem_addr);
                end
            end
        end
        tick();
        dbg_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_req_ready !== 1'b0 || if_stall !== 1'b0 || if_instr !== 32'h103) begin
            errors++;
            $display("FAIL dbg_release: rdy=%b stall=%b instr=%h want 0,0,00000103", dbg_req_ready, if_stall, if_instr);
        end
    endtask

    task automatic test_load();
        logic [ILEN-1:0] b_addr [5];
        logic [IW-1:0]   b_data [5];
        logic            b_vld  [5];
        logic            b_act  [5];
        b_addr = '{ILEN'(0), ILEN'(1), ILEN'(32), ILEN'(2), ILEN'(3)};
        b_data = '{32'hA0, 32'hA1, 32'hBAD, 32'hA2, 32'hA3};
        b_vld  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        b_act  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tick();
        ld_active = 1'b1;
        @(negedge clk);
        checks++;
        if (if_stall !== 1'b1 || ld_ready !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL load_entry: stall=%b ldr=%b we=%b want 1,0,0", if_stall, ld_ready, mem_we);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            ld_valid  = b_vld[i];
            ld_addr   = b_addr[i];
            ld_data   = b_data[i];
            ld_active = b_act[i];
            @(negedge clk);
            checks++;
            if (ld_ready !== 1'b1 || mem_we !== b_vld[i] || mem_en !== b_vld[i] || if_stall !== 1'b1 ||
                dbg_req_ready !== 1'b0 || if_instr !== 32'h103 ||
                (b_vld[i] && (mem_addr !== b_addr[i] || mem_wdata !== b_data[i]))) begin
                errors++;
                $display("FAIL load_beat[%0d]: ldr=%b we=%b en=%b addr=%h wd=%h stall=%b instr=%h (want 1,%b,%b,%h,%h,1,00000103)",
                         i, ld_ready, mem_we, mem_en, mem_addr, mem_wdata, if_stall, if_instr,
                         b_vld[i], b_vld[i], b_addr[i], b_data[i]);
            end
        end
        tick();
        ld_valid = 1'b0;
        if_addr  = ILEN'(0);
        @(negedge clk);
        checks++;
        if (if_flush !== 1'b1 || if_stall !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL load_flush: flush=%b stall=%b en=%b want 1,1,0", if_flush, if_stall, mem_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_flush !== 1'b0 || if_instr !== NOP || if_stall !== 1'b0 || mem_addr !== ILEN'(0) || mem_en !== 1'b1) begin
            errors++;
            $display("FAIL post_flush: flush=%b instr=%h stall=%b addr=%h en=%b want 0,%h,0,0000,1",
                     if_flush, if_instr, if_stall, mem_addr, mem_en, NOP);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_instr !== 32'hA0) begin
            errors++;
            $display("FAIL load_refetch: got %h want 000000a0", if_instr);
        end
        checks++;
        if (mem[0] !== 32'hA0 || mem[1] !== 32'hA1 || mem[2] !== 32'hA2 || mem[3] !== 32'hA3 || mem[32] !== 32'h0) begin
            errors++;
            $display("FAIL load_image: %h %h %h %h gap=%h want a0 a1 a2 a3 gap=0",
                     mem[0], mem[1], mem[2], mem[3], mem[32]);
        end
    endtask

    task automatic test_dbg_vs_load();
        logic exp_rdy [4];
        logic exp_fl  [4];
        exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_fl  = '{1'b0, 1'b0, 1'b1, 1'b0};
        tick();
        dbg_req_valid = 1'b1;
        dbg_addr      = ILEN'(16);
        ld_active     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            if (i == 1) ld_active = 1'b0;
            @(negedge clk);
            checks++;
            if (dbg_req_ready !== exp_rdy[i] || if_flush !== exp_fl[i]) begin
                errors++;
                $display("FAIL dbg_vs_load[%0d]: rdy=%b flush=%b want %b,%b", i, dbg_req_ready, if_flush, exp_rdy[i], exp_fl[i]);
            end
        end
        checks++;
        if (mem_addr !== ILEN'(16)) begin
            errors++;
            $display("FAIL dbg_vs_load_addr: got %h want 0010", mem_addr);
        end
        tick();
        dbg_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_rsp_valid !== 1'b1 || dbg_rsp_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL dbg_vs_load_rsp: v=%b data=%h want 1,deadbeef", dbg_rsp_valid, dbg_rsp_data);
        end
    endtask

    task automatic test_load_in_rsp();
        tick();
        dbg_req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_load_hs: rdy=%b want 1", dbg_req_ready);
        end
        tick();
        dbg_req_valid = 1'b0;
        ld_active     = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_rsp_valid !== 1'b1 || dbg_rsp_data !== 32'hDEADBEEF || if_stall !== 1'b0 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL rsp_load_rsp: v=%b data=%h stall=%b ldr=%b want 1,deadbeef,0,0",
                     dbg_rsp_valid, dbg_rsp_data, if_stall, ld_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (dbg_rsp_valid !== 1'b0 || if_stall !== 1'b1 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL rsp_load_fetch: v=%b stall=%b ldr=%b want 0,1,0", dbg_rsp_valid, if_stall, ld_ready);
        end
        tick();
        ld_active = 1'b0;
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_load_enter: ldr=%b want 1", ld_ready);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_load();
        tick();
        ld_active = 1'b1;
        tick();
        ld_valid = 1'b1;
        ld_addr  = ILEN'(5);
        ld_data  = 32'h55;
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b1 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_load_beat: ldr=%b we=%b want 1,1", ld_ready, mem_we);
        end
        tick();
        ld_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b0 || if_stall !== 1'b0 || if_flush !== 1'b0 || mem_en !== 1'b0 ||
            mem_we !== 1'b0 || if_instr !== NOP || dbg_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: ldr=%b stall=%b flush=%b en=%b we=%b instr=%h rdy=%b want 0,0,0,0,0,%h,0",
                     ld_ready, if_stall, if_flush, mem_en, mem_we, if_instr, dbg_req_ready, NOP);
        end
        tick();
        rst_n     = 1'b1;
        ld_active = 1'b0;
        if_addr   = ILEN'(1);
        @(negedge clk);
        checks++;
        if (if_flush !== 1'b0 || if_stall !== 1'b0 || mem_en !== 1'b1 || mem_addr !== ILEN'(1)) begin
            errors++;
            $display("FAIL rst_resume: flush=%b stall=%b en=%b addr=%h want 0,0,1,0001", if_flush, if_stall, mem_en, mem_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_instr !== 32'hA1 || if_flush !== 1'b0 || mem[5] !== 32'h55) begin
            errors++;
            $display("FAIL rst_refetch: instr=%h flush=%b mem5=%h want a1,0,55", if_instr, if_flush, mem[5]);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        preload       = 1'b1;
        rst_n         = 1'b0;
        if_addr       = '0;
        dbg_req_valid = 1'b0;
        dbg_addr      = '0;
        ld_active     = 1'b0;
        ld_valid      = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        test_reset();
        test_fetch();
        test_dbg_alternate();
        test_load();
        test_dbg_vs_load();
        test_load_in_rsp();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
